// File: rtl/csr_pkg.sv
// Shared types and address decode for the csr_bank register block.
package csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_HOLD
    } csr_state_t;

    typedef enum logic [1:0] {
        CFG,
        STS,
        INVALID
    } access_t;

    function automatic access_t classify_addr(input int unsigned addr,
                                              input int unsigned num_cfg,
                                              input int unsigned num_sts);
        access_t result;
        if (addr < num_cfg) begin
            result = CFG;
        end else if (addr < num_cfg + num_sts) begin
            result = STS;
        end else begin
            result = INVALID;
        end
        return result;
    endfunction

endpackage

// File: rtl/csr_bank_if.sv
// Host-side register port: asynchronous level strobes, level acknowledges.
interface csr_bank_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] write_data_i;
    logic                  write_en_i;
    logic                  read_en_i;
    logic                  write_ack_o;
    logic                  read_valid_o;
    logic [DATA_WIDTH-1:0] read_data_o;
    logic                  err_o;

    modport master (
        output addr_i, write_data_i, write_en_i, read_en_i,
        input  write_ack_o, read_valid_o, read_data_o, err_o
    );

    modport slave (
        input  addr_i, write_data_i, write_en_i, read_en_i,
        output write_ack_o, read_valid_o, read_data_o, err_o
    );
endinterface

// File: rtl/sync_edge_detect.sv
// Strobe synchroniser: SYNC_STAGES flop chain plus a delay flop and rise pulse.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    // Level is taken after the delay flop so the release path matches the
    // rise path in latency.
    assign level_o = dly_q;
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/csr_bank.sv
// Parametrised config/status register bank behind an asynchronous host port.
//   state     | meaning
//   ST_IDLE   | waiting for a synchronised write or read rise
//   ST_ACCESS | one cycle: commit write / load read data, raise ack
//   ST_HOLD   | ack held until the accessed strobe is seen low
module csr_bank
    import csr_pkg::*;
#(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CONFIG_REG = 12,
    parameter int NUM_STATUS_REG = 4,
    parameter int SYNC_STAGES    = 2,
    parameter logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] CONFIG_RESET_VAL   = '0,
    parameter logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] CONFIG_WR_MASK     = '1,
    parameter logic [DATA_WIDTH*NUM_STATUS_REG-1:0] STATUS_STICKY_MASK = '0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n,
    csr_bank_if.slave                              host,
    output logic                                   irq_o,
    output logic [DATA_WIDTH*NUM_CONFIG_REG-1:0]   config_bus_o,
    input  logic [DATA_WIDTH*NUM_STATUS_REG-1:0]   status_bus_i
);

    localparam int DW = DATA_WIDTH;
    localparam int NC = NUM_CONFIG_REG;
    localparam int NS = NUM_STATUS_REG;

    csr_state_t state_q, state_d;

    logic wr_level, wr_rise, rd_level, rd_rise;
    logic capture, do_access, release_ack;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DW-1:0]         wdata_q;
    logic                  is_write_q;
    access_t               acc_type;

    logic [DW-1:0]    cfg_q [NC];
    logic [DW*NS-1:0] sticky_q, live_q, sts_view, sts_clr;
    logic [DW-1:0]    rd_mux;

    logic [DW-1:0] read_data_q;
    logic          write_ack_q, read_valid_q, err_q;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .async_i (host.write_en_i),
        .level_o (wr_level),
        .rise_o  (wr_rise)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .async_i (host.read_en_i),
        .level_o (rd_level),
        .rise_o  (rd_rise)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        do_access   = 1'b0;
        release_ack = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_rise || rd_rise) begin
                    capture = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                do_access = 1'b1;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (!(is_write_q ? wr_level : rd_level)) begin
                    release_ack = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign acc_type = classify_addr(32'(addr_q), NC, NS);

    // Sticky bits read the held value, the rest read the registered raw status.
    assign sts_view = (sticky_q & STATUS_STICKY_MASK) | (live_q & ~STATUS_STICKY_MASK);
    assign irq_o    = |sticky_q;

    always_comb begin
        rd_mux = '1;
        for (int i = 0; i < NC; i++) begin
            if (addr_q == ADDR_WIDTH'(i)) rd_mux = cfg_q[i];
        end
        for (int j = 0; j < NS; j++) begin
            if (addr_q == ADDR_WIDTH'(NC + j)) rd_mux = sts_view[j*DW +: DW];
        end
    end

    always_comb begin
        sts_clr = '0;
        if (do_access && is_write_q) begin
            for (int j = 0; j < NS; j++) begin
                if (addr_q == ADDR_WIDTH'(NC + j)) sts_clr[j*DW +: DW] = wdata_q;
            end
        end
    end

    // Raw status is OR-ed in after the clear so a same-cycle set survives.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            sticky_q <= '0;
            live_q   <= '0;
        end else begin
            sticky_q <= ((sticky_q & ~sts_clr) | status_bus_i) & STATUS_STICKY_MASK;
            live_q   <= status_bus_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            for (int i = 0; i < NC; i++) begin
                cfg_q[i] <= CONFIG_RESET_VAL[i*DW +: DW];
            end
        end else if (do_access && is_write_q) begin
            for (int i = 0; i < NC; i++) begin
                if (addr_q == ADDR_WIDTH'(i)) begin
                    cfg_q[i] <= (cfg_q[i] & ~CONFIG_WR_MASK[i*DW +: DW])
                              | (wdata_q  &  CONFIG_WR_MASK[i*DW +: DW]);
                end
            end
        end
    end

    always_comb begin
        config_bus_o = '0;
        for (int i = 0; i < NC; i++) begin
            config_bus_o[i*DW +: DW] = cfg_q[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            is_write_q   <= 1'b0;
            read_data_q  <= '0;
            write_ack_q  <= 1'b0;
            read_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (capture) begin
                addr_q     <= host.addr_i;
                is_write_q <= wr_rise;
                if (wr_rise) wdata_q <= host.write_data_i;
            end
            if (do_access) begin
                err_q        <= (acc_type == INVALID);
                write_ack_q  <= is_write_q;
                read_valid_q <= !is_write_q;
                if (!is_write_q) read_data_q <= rd_mux;
            end
            if (release_ack) begin
                write_ack_q  <= 1'b0;
                read_valid_q <= 1'b0;
            end
        end
    end

    assign host.write_ack_o  = write_ack_q;
    assign host.read_valid_o = read_valid_q;
    assign host.read_data_o  = read_data_q;
    assign host.err_o        = err_q;

endmodule

// File: tb/tb_csr_bank.sv
// Self-checking bench for csr_bank: vector table with scoreboard plus corner sequences.
module tb_csr_bank;

    localparam int AW = 7;
    localparam int DW = 8;
    localparam int NC = 12;
    localparam int NS = 4;
    localparam logic [DW*NC-1:0] CFG_RST  = 96'h0000_0000_0000_0000_0000_00CC;
    localparam logic [DW*NC-1:0] CFG_MASK = 96'hFFFF_FFFF_FFFF_FFFF_0FFF_FFFF;
    localparam logic [DW*NS-1:0] STICKY   = 32'h0000_0001;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_rd;
        bit            exp_err;
        int            cfg_idx;
        logic [DW-1:0] exp_cfg;
    } vec_t;

    logic             clk_i = 1'b0;
    logic             rst_n;
    logic [DW*NS-1:0] status_bus;
    logic [DW*NC-1:0] config_bus;
    logic             irq;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] last_rd;
    logic          irq_at_ack;
    vec_t          sb[$];
    vec_t          vecs[14];

    csr_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    csr_bank #(
        .ADDR_WIDTH         (AW),
        .DATA_WIDTH         (DW),
        .NUM_CONFIG_REG     (NC),
        .NUM_STATUS_REG     (NS),
        .SYNC_STAGES        (2),
        .CONFIG_RESET_VAL   (CFG_RST),
        .CONFIG_WR_MASK     (CFG_MASK),
        .STATUS_STICKY_MASK (STICKY)
    ) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .host         (bus),
        .irq_o        (irq),
        .config_bus_o (config_bus),
        .status_bus_i (status_bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [DW-1:0] rd, input bit err, input int ci,
                                input logic [DW-1:0] c);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.exp_rd = rd;
        v.exp_err = err; v.cfg_idx = ci; v.exp_cfg = c;
        return v;
    endfunction

    task automatic wait_ack_fall(input string name);
        int n = 0;
        while ((bus.write_ack_o || bus.read_valid_o) && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check(name, 128'(n), 128'(4));
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int   n = 0;
        bit   seen = 1'b0;
        sb.push_back(v);
        @(negedge clk_i);
        bus.addr_i       = v.addr;
        bus.write_data_i = v.data;
        if (v.wr) bus.write_en_i = 1'b1;
        else      bus.read_en_i  = 1'b1;
        while (!seen && n < 20) begin
            @(negedge clk_i);
            n++;
            if (v.wr ? bus.write_ack_o : bus.read_valid_o) seen = 1'b1;
        end
        irq_at_ack = irq;
        check($sformatf("ack_rise@%0d", v.addr), 128'(n), 128'(4));
        e = sb.pop_front();
        check($sformatf("err@%0d", e.addr), 128'(bus.err_o), 128'(e.exp_err));
        if (e.wr) begin
            check($sformatf("rd_hold@%0d", e.addr), 128'(bus.read_data_o), 128'(last_rd));
            if (e.cfg_idx >= 0)
                check($sformatf("cfg%0d", e.cfg_idx), 128'(config_bus[e.cfg_idx*DW +: DW]),
                      128'(e.exp_cfg));
        end else begin
            check($sformatf("rd_data@%0d", e.addr), 128'(bus.read_data_o), 128'(e.exp_rd));
            last_rd = e.exp_rd;
        end
        bus.write_en_i = 1'b0;
        bus.read_en_i  = 1'b0;
        wait_ack_fall($sformatf("ack_fall@%0d", v.addr));
    endtask

    initial begin
        int  n;
        bit  rv_seen;
        int  extra_acks;

        vecs[0]  = mk(0, 7'd0,  8'h00, 8'hCC, 0, -1, 8'h00);
        vecs[1]  = mk(1, 7'd3,  8'hA5, 8'h00, 0,  3, 8'h05);
        vecs[2]  = mk(0, 7'd3,  8'h00, 8'h05, 0, -1, 8'h00);
        vecs[3]  = mk(1, 7'd5,  8'h3C, 8'h00, 0,  5, 8'h3C);
        vecs[4]  = mk(0, 7'd5,  8'h00, 8'h3C, 0, -1, 8'h00);
        vecs[5]  = mk(0, 7'd20, 8'h00, 8'hFF, 1, -1, 8'h00);
        vecs[6]  = mk(0, 7'd0,  8'h00, 8'hCC, 0, -1, 8'h00);
        vecs[7]  = mk(1, 7'd16, 8'h77, 8'h00, 1,  0, 8'hCC);
        vecs[8]  = mk(0, 7'd11, 8'h00, 8'h00, 0, -1, 8'h00);
        vecs[9]  = mk(1, 7'd0,  8'h12, 8'h00, 0,  0, 8'h12);
        vecs[10] = mk(0, 7'd0,  8'h00, 8'h12, 0, -1, 8'h00);
        vecs[11] = mk(0, 7'd13, 8'h00, 8'h5A, 0, -1, 8'h00);
        vecs[12] = mk(1, 7'd13, 8'hFF, 8'h00, 0, -1, 8'h00);
        vecs[13] = mk(0, 7'd15, 8'h00, 8'h00, 0, -1, 8'h00);

        rst_n            = 1'b0;
        bus.addr_i       = '0;
        bus.write_data_i = '0;
        bus.write_en_i   = 1'b0;
        bus.read_en_i    = 1'b0;
        status_bus       = '0;
        last_rd          = '0;
        irq_at_ack       = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_n = 1'b1;
        @(negedge clk_i);

        check("rst_cfg_bus",   128'(config_bus),       128'(CFG_RST));
        check("rst_write_ack", 128'(bus.write_ack_o),  128'(0));
        check("rst_read_vld",  128'(bus.read_valid_o), 128'(0));
        check("rst_read_data", 128'(bus.read_data_o),  128'(0));
        check("rst_err",       128'(bus.err_o),        128'(0));
        check("rst_irq",       128'(irq),              128'(0));

        status_bus[15:8] = 8'h5A;
        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // Sticky status bit 0: one-cycle raw pulse, then W1C, then set-vs-clear race.
        @(negedge clk_i);
        status_bus[0] = 1'b1;
        @(negedge clk_i);
        status_bus[0] = 1'b0;
        check("irq_set", 128'(irq), 128'(1));
        repeat (2) @(negedge clk_i);
        check("irq_held", 128'(irq), 128'(1));
        run_vec(mk(0, 7'd12, 8'h00, 8'h01, 0, -1, 8'h00));
        run_vec(mk(1, 7'd12, 8'h01, 8'h00, 0, -1, 8'h00));
        check("irq_w1c_at_ack", 128'(irq_at_ack), 128'(0));
        check("irq_w1c", 128'(irq), 128'(0));
        status_bus[0] = 1'b1;
        @(negedge clk_i);
        run_vec(mk(1, 7'd12, 8'h01, 8'h00, 0, -1, 8'h00));
        check("irq_set_wins", 128'(irq_at_ack), 128'(1));
        run_vec(mk(0, 7'd12, 8'h00, 8'h01, 0, -1, 8'h00));
        status_bus[0] = 1'b0;
        @(negedge clk_i);
        run_vec(mk(1, 7'd12, 8'h01, 8'h00, 0, -1, 8'h00));
        check("irq_cleared", 128'(irq), 128'(0));

        // Write and read strobes rise together: write wins, read is dropped.
        @(negedge clk_i);
        bus.addr_i       = 7'd4;
        bus.write_data_i = 8'h99;
        bus.write_en_i   = 1'b1;
        bus.read_en_i    = 1'b1;
        n       = 0;
        rv_seen = 1'b0;
        while (!bus.write_ack_o && n < 20) begin
            @(negedge clk_i);
            n++;
            if (bus.read_valid_o) rv_seen = 1'b1;
        end
        check("both_ack_rise", 128'(n), 128'(4));
        check("both_cfg4",     128'(config_bus[4*DW +: DW]), 128'(8'h99));
        check("both_rd_hold",  128'(bus.read_data_o), 128'(last_rd));
        bus.write_en_i = 1'b0;
        bus.read_en_i  = 1'b0;
        wait_ack_fall("both_ack_fall");
        repeat (6) begin
            @(negedge clk_i);
            if (bus.read_valid_o) rv_seen = 1'b1;
        end
        check("both_no_read", 128'(rv_seen), 128'(0));

        // Reset during ACCESS; the strobe stays high through reset release.
        @(negedge clk_i);
        bus.addr_i       = 7'd6;
        bus.write_data_i = 8'h42;
        bus.write_en_i   = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_i);
        check("midrst_cfg_bus", 128'(config_bus), 128'(CFG_RST));
        check("midrst_ack",     128'(bus.write_ack_o), 128'(0));
        rst_n = 1'b1;
        n = 0;
        while (!bus.write_ack_o && n < 20) begin
            @(negedge clk_i);
            n++;
            if (n == 1) check("release_cfg_bus", 128'(config_bus), 128'(CFG_RST));
        end
        check("release_ack_rise", 128'(n), 128'(4));
        check("release_cfg6", 128'(config_bus[6*DW +: DW]), 128'(8'h42));
        bus.write_en_i = 1'b0;
        wait_ack_fall("release_ack_fall");
        extra_acks = 0;
        repeat (8) begin
            @(negedge clk_i);
            if (bus.write_ack_o) extra_acks++;
        end
        check("release_once", 128'(extra_acks), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
